imem_loader: RTL and testbench

Write side of the fetch-stage instruction memory. It accepts a byte stream over a valid/ready handshake and stores it into a 256-byte instruction RAM. While loading, it holds the pipeline so fetch cannot read a partially loaded program. The read port has the same semantics as the fetch-side instruction memory: it returns the big-endian word at byte address A. It sits between the external program source and the PC/IF_ID front end, and drives PC enable gating through `cpu_hold`.

---
 rtl/imem_loader.sv | 133 +++++++++++++
 tb/tb_imem_loader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Byte-stream loader for the fetch-stage instruction RAM; holds the
//            CPU while a program is written and serves big-endian word reads.
// Revision : 1.0  initial release
// ============================================================================
module imem_loader #(
    parameter int AW    = 8,
    parameter int DEPTH = 1 << AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_start,
    input  logic [AW:0]   load_len,
    input  logic          load_abort,
    input  logic [7:0]    in_byte,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          cpu_hold,
    output logic [AW:0]   bytes_loaded,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_instr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0] LEN_ONE = (AW+1)'(1);

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   remaining_q, remaining_d;
    logic [AW:0]   bytes_loaded_q, bytes_loaded_d;
    logic          err_q, err_d;
    logic          mem_we;
    logic          len_ok;

    logic [7:0]    mem [DEPTH];

    assign len_ok = (load_len != '0) && (load_len <= LEN_MAX);

    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        remaining_d    = remaining_q;
        bytes_loaded_d = bytes_loaded_q;
        err_d          = 1'b0;
        mem_we         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    if (len_ok) begin
                        remaining_d    = load_len;
                        wr_ptr_d       = '0;
                        bytes_loaded_d = '0;
                        state_d        = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                // An abort suppresses the byte offered on the same edge.
                if (load_abort) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (in_valid) begin
                    mem_we         = 1'b1;
                    wr_ptr_d       = wr_ptr_q + AW'(1);
                    remaining_d    = remaining_q - LEN_ONE;
                    bytes_loaded_d = bytes_loaded_q + LEN_ONE;
                    if (remaining_q == LEN_ONE) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            wr_ptr_q       <= '0;
            remaining_q    <= '0;
            bytes_loaded_q <= '0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            remaining_q    <= remaining_d;
            bytes_loaded_q <= bytes_loaded_d;
            err_q          <= err_d;
        end
    end

    // Contents survive reset; a full-depth load wraps the pointer back to 0.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= in_byte;
        end
    end

    logic [AW-1:0] rd_a1, rd_a2, rd_a3;
    assign rd_a1 = rd_addr + AW'(1);
    assign rd_a2 = rd_addr + AW'(2);
    assign rd_a3 = rd_addr + AW'(3);

    assign rd_instr     = {mem[rd_addr], mem[rd_a1], mem[rd_a2], mem[rd_a3]};

    assign in_ready     = (state_q == S_LOAD);
    assign busy         = (state_q == S_LOAD);
    assign done         = (state_q == S_DONE);
    assign cpu_hold     = (state_q == S_LOAD) || (state_q == S_DONE);
    assign err          = err_q;
    assign bytes_loaded = bytes_loaded_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Directed self-checking bench for imem_loader with a read scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_start = 1'b0;
    logic [8:0]  load_len = '0;
    logic        load_abort = 1'b0;
    logic [7:0]  in_byte = '0;
    logic        in_valid = 1'b0;
    logic        in_ready, busy, done, err, cpu_hold;
    logic [8:0]  bytes_loaded;
    logic [7:0]  rd_addr = '0;
    logic [31:0] rd_instr;

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] mm  [256];
    logic [7:0] src [256];

    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] w;
    } rd_t;
    rd_t rdq [$];

    imem_loader dut (
        .clk          (clk),
        .reset        (reset),
        .load_start   (load_start),
        .load_len     (load_len),
        .load_abort   (load_abort),
        .in_byte      (in_byte),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .cpu_hold     (cpu_hold),
        .bytes_loaded (bytes_loaded),
        .rd_addr      (rd_addr),
        .rd_instr     (rd_instr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_rd(input logic [7:0] a);
        logic [7:0] a1, a2, a3;
        rd_t e;
        a1 = a + 8'd1;
        a2 = a + 8'd2;
        a3 = a + 8'd3;
        e.a = a;
        e.w = {mm[a], mm[a1], mm[a2], mm[a3]};
        rdq.push_back(e);
    endtask

    task automatic drain_rd(input string tag);
        rd_t e;
        while (rdq.size() > 0) begin
            e = rdq.pop_front();
            rd_addr = e.a;
            #1;
            chk(tag, rd_instr, e.w);
        end
    endtask

    task automatic run_load(input int len, input bit toggle, input bit poke, input string tag);
        int idx = 0;
        int dn = 0;
        int hold_bad = 0;
        int edges = 0;
        int done_edge = -1;
        bit v;
        load_len   = 9'(len);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk({tag, " busy_start"}, busy, 1);
        chk({tag, " ready_start"}, in_ready, 1);
        for (int c = 0; c < 1200 && dn == 0; c++) begin
            v = (idx < len) && (!toggle || c[0] == 1'b0);
            in_valid = v;
            in_byte  = (idx < len) ? src[idx] : 8'h00;
            if (poke) begin
                load_start = 1'b1;
                load_len   = 9'd3;
            end
            tick();
            edges++;
            if (v) begin
                mm[idx] = src[idx];
                idx++;
            end
            if (done === 1'b1) begin
                dn = 1;
                done_edge = edges;
            end else if (cpu_hold !== 1'b1) begin
                hold_bad++;
            end
        end
        in_valid = 1'b0;
        chk({tag, " done_seen"}, dn, 1);
        chk({tag, " hold_during_load"}, hold_bad, 0);
        chk({tag, " hold_in_done"}, cpu_hold, 1);
        chk({tag, " ready_in_done"}, in_ready, 0);
        chk({tag, " bytes_loaded"}, bytes_loaded, 32'(len));
        if (!toggle) chk({tag, " done_latency"}, done_edge, len);
        tick();
        load_start = 1'b0;
        chk({tag, " done_single"}, done, 0);
        chk({tag, " hold_after"}, cpu_hold, 0);
        chk({tag, " busy_after"}, busy, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mm[i] = 'x;

        // Reset state
        tick();
        tick();
        chk("reset busy", busy, 0);
        chk("reset ready", in_ready, 0);
        chk("reset hold", cpu_hold, 0);
        chk("reset done", done, 0);
        chk("reset err", err, 0);
        chk("reset count", bytes_loaded, 0);
        reset = 1'b0;
        tick();
        chk("idle ready", in_ready, 0);

        // Four-byte back-to-back load
        src[0] = 8'hE3; src[1] = 8'hA0; src[2] = 8'h10; src[3] = 8'h05;
        run_load(4, 1'b0, 1'b0, "len4");
        push_rd(8'd0);
        drain_rd("len4 rd");
        rd_addr = 8'd0; #1;
        chk("len4 word0", rd_instr, 32'hE3A01005);

        // Illegal lengths
        load_start = 1'b1; load_len = 9'd0;
        tick();
        load_start = 1'b0;
        chk("len0 err", err, 1);
        chk("len0 busy", busy, 0);
        chk("len0 ready", in_ready, 0);
        tick();
        chk("len0 err_pulse", err, 0);
        load_start = 1'b1; load_len = 9'd300;
        tick();
        load_start = 1'b0;
        chk("len300 err", err, 1);
        chk("len300 ready", in_ready, 0);
        tick();
        chk("len300 err_pulse", err, 0);
        chk("len300 hold", cpu_hold, 0);
        push_rd(8'd0);
        drain_rd("illegal rd");

        // Full-depth load with in_valid toggling
        for (int i = 0; i < 256; i++) src[i] = 8'(i);
        run_load(256, 1'b1, 1'b0, "len256");
        push_rd(8'd254);
        push_rd(8'd100);
        push_rd(8'd0);
        drain_rd("len256 rd");
        rd_addr = 8'd254; #1;
        chk("len256 wrap", rd_instr, 32'hFEFF0001);

        // Abort on the edge of the third transfer
        src[0] = 8'hAA; src[1] = 8'hBB; src[2] = 8'hCC;
        load_start = 1'b1; load_len = 9'd8;
        tick();
        load_start = 1'b0;
        in_valid = 1'b1; in_byte = src[0];
        tick(); mm[0] = src[0];
        in_byte = src[1];
        tick(); mm[1] = src[1];
        in_byte = src[2]; load_abort = 1'b1;
        tick();
        load_abort = 1'b0; in_valid = 1'b0;
        chk("abort err", err, 1);
        chk("abort busy", busy, 0);
        chk("abort hold", cpu_hold, 0);
        chk("abort ready", in_ready, 0);
        chk("abort count", bytes_loaded, 2);
        tick();
        chk("abort err_pulse", err, 0);
        push_rd(8'd0);
        drain_rd("abort rd");
        rd_addr = 8'd0; #1;
        chk("abort word0", rd_instr, 32'hAABB0203);

        // load_start held during LOAD and DONE
        for (int i = 0; i < 6; i++) src[i] = 8'h30 + 8'(i);
        run_load(6, 1'b0, 1'b1, "poke");
        push_rd(8'd2);
        drain_rd("poke rd");

        // Asynchronous reset after five bytes
        for (int i = 0; i < 10; i++) src[i] = 8'h50 + 8'(i);
        load_start = 1'b1; load_len = 9'd10;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_byte = src[i];
            tick();
            mm[i] = src[i];
        end
        in_valid = 1'b0;
        chk("mid count", bytes_loaded, 5);
        #2 reset = 1'b1;
        #1;
        chk("async busy", busy, 0);
        chk("async ready", in_ready, 0);
        chk("async hold", cpu_hold, 0);
        chk("async done", done, 0);
        chk("async err", err, 0);
        chk("async count", bytes_loaded, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_reset err", err, 0);
        chk("post_reset busy", busy, 0);
        push_rd(8'd0);
        push_rd(8'd1);
        drain_rd("retain rd");
        for (int i = 0; i < 4; i++) src[i] = 8'h90 + 8'(i);
        run_load(4, 1'b0, 1'b0, "reload");
        push_rd(8'd0);
        push_rd(8'd2);
        drain_rd("reload rd");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
